// File: rtl/instr_encoder_loader_if.sv
// Field-bundle stream into the encoder plus the instruction-memory write port.
// master: the loader side; slave: the producer/memory side.
interface instr_encoder_loader_if #(
  parameter int unsigned IM_AW = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_sel;
  logic [4:0]       in_rs;
  logic [4:0]       in_rt;
  logic [4:0]       in_rd;
  logic [4:0]       in_shamt;
  logic [15:0]      in_imm;
  logic [25:0]      in_target;
  logic             in_last;
  logic             im_we;
  logic             im_ready;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_wdata;

  modport master (
    input  in_valid, in_sel, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
    output in_ready,
    output im_we, im_addr, im_wdata,
    input  im_ready
  );

  modport slave (
    output in_valid, in_sel, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
    input  in_ready,
    input  im_we, im_addr, im_wdata,
    output im_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes decoded instruction fields into MIPS words, buffers them in a FIFO
// and streams them sequentially into instruction memory from a base address.
module instr_encoder_loader #(
  parameter int unsigned IM_AW      = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [IM_AW-1:0]               base_addr,
  instr_encoder_loader_if.master         bus,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [IM_AW:0]                 count
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = IM_AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [PW:0]       wptr_q, wptr_d;
  logic [PW:0]       rptr_q, rptr_d;
  logic [IM_AW-1:0]  addr_q, addr_d;
  logic [IM_AW-1:0]  im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              im_we_q, im_we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CW-1:0]     count_q, count_d;

  logic              fifo_empty_c, fifo_full_c, in_ready_c, push_c;
  logic [31:0]       enc_word_c;
  logic              enc_legal_c;
  logic [5:0]        op_c, funct_c;
  logic [4:0]        rs_c, rt_c, rd_c, sh_c;

  assign fifo_empty_c = (wptr_q == rptr_q);
  assign fifo_full_c  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign in_ready_c   = (state_q == S_LOAD) && !fifo_full_c;

  // Field bundle to 32-bit instruction word; field forcing per instruction class.
  always_comb begin
    op_c        = 6'h00;
    funct_c     = 6'h00;
    enc_legal_c = 1'b1;
    rs_c        = bus.in_rs;
    rt_c        = bus.in_rt;
    rd_c        = bus.in_rd;
    sh_c        = 5'd0;
    case (bus.in_sel)
      5'd0:  funct_c = 6'h20;
      5'd1:  funct_c = 6'h22;
      5'd2:  funct_c = 6'h24;
      5'd3:  funct_c = 6'h25;
      5'd4:  funct_c = 6'h2A;
      5'd5:  funct_c = 6'h2B;
      5'd6:  funct_c = 6'h21;
      5'd7:  funct_c = 6'h23;
      5'd8:  funct_c = 6'h08;
      5'd9:  funct_c = 6'h09;
      5'd10: funct_c = 6'h27;
      5'd11: funct_c = 6'h00;
      5'd12: funct_c = 6'h02;
      5'd13: funct_c = 6'h03;
      5'd14: funct_c = 6'h04;
      5'd15: funct_c = 6'h06;
      5'd16: op_c    = 6'h08;
      5'd17: op_c    = 6'h0D;
      5'd18: op_c    = 6'h23;
      5'd19: op_c    = 6'h2B;
      5'd20: op_c    = 6'h04;
      5'd21: op_c    = 6'h05;
      5'd22: op_c    = 6'h0A;
      5'd23: op_c    = 6'h02;
      5'd24: op_c    = 6'h03;
      default: enc_legal_c = 1'b0;
    endcase
    if (bus.in_sel >= 5'd11 && bus.in_sel <= 5'd13) begin
      sh_c = bus.in_shamt;
      rs_c = 5'd0;
    end
    if (bus.in_sel == 5'd8) begin
      rt_c = 5'd0;
      rd_c = 5'd0;
    end
    if (bus.in_sel == 5'd9) rt_c = 5'd0;
    if (bus.in_sel < 5'd16)      enc_word_c = {6'b0, rs_c, rt_c, rd_c, sh_c, funct_c};
    else if (bus.in_sel < 5'd23) enc_word_c = {op_c, bus.in_rs, bus.in_rt, bus.in_imm};
    else                         enc_word_c = {op_c, bus.in_target};
  end

  // Session FSM, FIFO pointers and IM write-side next state.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    addr_d     = addr_q;
    count_d    = count_q;
    err_d      = err_q;
    done_d     = 1'b0;
    im_we_d    = im_we_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    push_c     = 1'b0;

    if (im_we_q && bus.im_ready) begin
      addr_d  = addr_q + IM_AW'(1);
      count_d = count_q + CW'(1);
      im_we_d = 1'b0;
    end
    // Refill the write register as soon as the current word is gone or accepted.
    if (state_q != S_IDLE && (!im_we_q || bus.im_ready) && !fifo_empty_c) begin
      rptr_d     = rptr_q + (PW+1)'(1);
      im_we_d    = 1'b1;
      im_addr_d  = addr_d;
      im_wdata_d = fifo_q[rptr_q[PW-1:0]];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = base_addr;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.in_valid && in_ready_c) begin
          if (enc_legal_c) begin
            push_c = 1'b1;
            wptr_d = wptr_q + (PW+1)'(1);
          end else begin
            err_d = 1'b1;
          end
          if (bus.in_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_empty_c && !im_we_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      done_q     <= done_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wptr_q[PW-1:0]] <= enc_word_c;
  end

  assign bus.in_ready = in_ready_c;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wdata = im_wdata_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign count        = count_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed sessions plus randomized sessions
// scored against a table-driven encoding model and an expected-write queue.
module tb_instr_encoder_loader;
  localparam int unsigned IM_AW      = 10;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef struct {
    int sel; int rs; int rt; int rd; int sh; int imm; int tgt; bit last;
  } bun_t;
  typedef struct {
    logic [IM_AW-1:0] a; logic [31:0] d;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [IM_AW-1:0] base_addr;
  logic             busy, done, err;
  logic [IM_AW:0]   count;

  instr_encoder_loader_if #(.IM_AW(IM_AW)) bus ();

  instr_encoder_loader #(.IM_AW(IM_AW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .bus(bus),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  int               n_cmp = 0;
  int               n_bad = 0;
  int               ready_mode = 0;
  int               done_cnt = 0;
  exp_t             exp_q[$];
  logic [IM_AW-1:0] m_addr;
  logic [IM_AW:0]   m_cnt;
  logic             m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Encoding model from the opcode/funct tables and field-forcing rules.
  function automatic logic [31:0] model_enc(input bun_t b, output bit legal);
    longint r_funct[16] = '{32, 34, 36, 37, 42, 43, 33, 35, 8, 9, 39, 0, 2, 3, 4, 6};
    longint i_op[7]     = '{8, 13, 35, 43, 4, 5, 10};
    longint j_op[2]     = '{2, 3};
    longint w;
    longint f_rs, f_rt, f_rd, f_sh;
    bit shift;
    legal = 1'b1;
    if (b.sel < 16) begin
      shift = (b.sel >= 11 && b.sel <= 13);
      f_rs  = shift ? 0 : b.rs;
      f_rt  = (b.sel == 8 || b.sel == 9) ? 0 : b.rt;
      f_rd  = (b.sel == 8) ? 0 : b.rd;
      f_sh  = shift ? b.sh : 0;
      w = f_rs * 2097152 + f_rt * 65536 + f_rd * 2048 + f_sh * 64 + r_funct[b.sel];
    end else if (b.sel < 23) begin
      w = i_op[b.sel-16] * 67108864 + longint'(b.rs) * 2097152 + longint'(b.rt) * 65536 + b.imm;
    end else if (b.sel < 25) begin
      w = j_op[b.sel-23] * 67108864 + b.tgt;
    end else begin
      legal = 1'b0;
      w = 0;
    end
    return 32'(w);
  endfunction

  function automatic bun_t rnd_bun(input int sel_max);
    bun_t b;
    b.sel  = int'($urandom_range(0, sel_max));
    b.rs   = int'($urandom_range(0, 31));
    b.rt   = int'($urandom_range(0, 31));
    b.rd   = int'($urandom_range(0, 31));
    b.sh   = int'($urandom_range(0, 31));
    b.imm  = int'($urandom_range(0, 65535));
    b.tgt  = int'($urandom_range(0, 67108863));
    b.last = 1'b0;
    return b;
  endfunction

  function automatic bun_t mk(input int sel, rs, rt, rd, sh, imm, tgt, input bit last);
    bun_t b;
    b.sel = sel; b.rs = rs; b.rt = rt; b.rd = rd; b.sh = sh;
    b.imm = imm; b.tgt = tgt; b.last = last;
    return b;
  endfunction

  task automatic drive(input bun_t b);
    bus.in_sel    = 5'(b.sel);
    bus.in_rs     = 5'(b.rs);
    bus.in_rt     = 5'(b.rt);
    bus.in_rd     = 5'(b.rd);
    bus.in_shamt  = 5'(b.sh);
    bus.in_imm    = 16'(b.imm);
    bus.in_target = 26'(b.tgt);
    bus.in_last   = b.last;
  endtask

  // Record the effect of a bundle that the coming edge accepts.
  task automatic note_accept(input bun_t b, input bit use_lit, input logic [31:0] lit);
    bit legal;
    logic [31:0] w;
    w = model_enc(b, legal);
    if (use_lit) w = lit;
    if (legal) begin
      exp_q.push_back('{a: m_addr, d: w});
      m_addr = m_addr + IM_AW'(1);
      m_cnt  = m_cnt + (IM_AW+1)'(1);
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic send(input bun_t b, input bit use_lit, input logic [31:0] lit);
    int k;
    drive(b);
    bus.in_valid = 1'b1;
    for (k = 0; k < 300; k++) begin
      if (bus.in_ready) break;
      tick();
    end
    check("accept_wait", bus.in_ready, 1);
    note_accept(b, use_lit, lit);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic begin_session(input logic [IM_AW-1:0] base);
    start = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
    m_addr = base;
    m_cnt  = '0;
    m_err  = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_after_start", err, 0);
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 1000; k++) begin
      if (done) break;
      tick();
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_count"}, count, m_cnt);
    check({tag, "_err"}, err, m_err);
    check({tag, "_pending"}, exp_q.size(), 0);
    tick();
  endtask

  task automatic rnd_session(input logic [IM_AW-1:0] base, input int n, input bit poke_start);
    bun_t b;
    begin_session(base);
    if (poke_start) begin
      start = 1'b1;
      base_addr = IM_AW'($urandom);
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      b = rnd_bun(31);
      b.last = (i == n - 1);
      send(b, 1'b0, 32'h0);
    end
    wait_done("rnd");
  endtask

  // Drives im_ready: 0 = always ready, 1 = random, otherwise stalled.
  initial begin
    bus.im_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.im_ready = 1'b1;
        1:       bus.im_ready = 1'($urandom_range(0, 1));
        default: bus.im_ready = 1'b0;
      endcase
    end
  end

  // Write-port monitor: ordering, data, hold-while-stalled and done width.
  logic             stall_s = 1'b0;
  logic             done_prev = 1'b0;
  logic [IM_AW-1:0] hold_a;
  logic [31:0]      hold_d;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_s   = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (stall_s) begin
        check("hold_we", bus.im_we, 1);
        check("hold_addr", bus.im_addr, hold_a);
        check("hold_data", bus.im_wdata, hold_d);
      end
      if (bus.im_we && bus.im_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", bus.im_addr, e.a);
          check("wr_data", bus.im_wdata, e.d);
        end
      end
      stall_s = bus.im_we && !bus.im_ready;
      hold_a  = bus.im_addr;
      hold_d  = bus.im_wdata;
      if (done) begin
        check("done_width", done_prev, 0);
        done_cnt++;
      end
      done_prev = done;
    end
  end

  initial begin
    bun_t bp[6];
    int   acc;
    int   dc;

    rst = 1'b1; start = 1'b0; base_addr = '0;
    bus.in_valid = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1'b0));
    m_addr = '0; m_cnt = '0; m_err = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_im_we", bus.im_we, 0);
    check("rst_im_addr", bus.im_addr, 0);
    check("rst_im_wdata", bus.im_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_count", count, 0);

    // Single addi.
    begin_session(10'h010);
    send(mk(16, 0, 8, 0, 0, 16'h0005, 0, 1'b1), 1'b1, 32'h20080005);
    wait_done("addi");

    // Mixed formats, consecutive addresses.
    begin_session(10'h020);
    send(mk(0, 9, 10, 8, 3, 0, 0, 1'b0), 1'b1, 32'h012A4020);
    send(mk(19, 29, 31, 0, 0, 16'hFFFC, 0, 1'b0), 1'b1, 32'hAFBFFFFC);
    send(mk(23, 0, 0, 0, 0, 0, 26'h0100000, 1'b0), 1'b1, 32'h08100000);
    send(mk(11, 5, 0, 0, 0, 0, 0, 1'b1), 1'b1, 32'h00000000);
    wait_done("stream");

    // Back-pressure: memory stalled while six bundles are offered.
    ready_mode = 2;
    repeat (2) tick();
    for (int i = 0; i < 6; i++) begin
      bp[i] = rnd_bun(24);
      bp[i].last = (i == 5);
    end
    begin_session(10'h100);
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      if (acc < 6) begin
        drive(bp[acc]);
        bus.in_valid = 1'b1;
        if (bus.in_ready) begin
          note_accept(bp[acc], 1'b0, 32'h0);
          acc++;
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    check("bp_accepts", acc, FIFO_DEPTH + 1);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_count", count, 0);
    ready_mode = 0;
    for (int i = acc; i < 6; i++) send(bp[i], 1'b0, 32'h0);
    wait_done("bp");

    // Address wrap.
    begin_session(10'h3FF);
    begin
      bun_t w0, w1;
      w0 = rnd_bun(24);
      w1 = rnd_bun(24);
      w1.last = 1'b1;
      send(w0, 1'b0, 32'h0);
      send(w1, 1'b0, 32'h0);
    end
    wait_done("wrap");
    check("wrap_count2", count, 2);

    // Illegal select in the middle of a session.
    begin_session(10'h050);
    send(mk(17, 3, 4, 0, 0, 16'h1234, 0, 1'b0), 1'b1, 32'h34641234);
    send(mk(27, 1, 2, 3, 4, 5, 6, 1'b0), 1'b0, 32'h0);
    send(mk(16, 1, 2, 0, 0, 16'h8000, 0, 1'b1), 1'b1, 32'h20228000);
    wait_done("illegal");
    check("illegal_err_sticky", err, 1);

    // Randomized sessions with random memory readiness; start is poked mid-session.
    ready_mode = 1;
    rnd_session(10'h060, 8, 1'b1);
    for (int s = 0; s < 3; s++) rnd_session(IM_AW'($urandom), int'($urandom_range(3, 12)), 1'b0);

    // Reset mid-session with the FIFO holding words.
    ready_mode = 2;
    repeat (2) tick();
    begin_session(10'h200);
    for (int i = 0; i < 3; i++) send(rnd_bun(24), 1'b0, 32'h0);
    check("pre_rst_im_we", bus.im_we, 1);
    dc = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("midrst_im_we", bus.im_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", count, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_im_addr", bus.im_addr, 0);
    repeat (5) tick();
    check("midrst_no_done", done_cnt, dc);
    check("midrst_idle_we", bus.im_we, 0);
    ready_mode = 1;
    rnd_session(10'h2A0, 6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the main-control decoder. Takes decoded instruction fields over a valid/ready stream and encodes each into a 32-bit MIPS word.
- Words are buffered in a small FIFO, then written sequentially into instruction memory through its write port.
- Used by test harnesses and boot logic to load programs that use only the instruction subset the CPU decodes.

Parameters:
- IM_AW, 10, IM word-address width.
- FIFO_DEPTH, 4, encoded-word buffer depth (power of 2, at least 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a load session (ignored while busy)
- base_addr  in  IM_AW  first IM word address, latched on start
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_sel  in  5  instruction select (table below)
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
- in_imm  in  16  I-type immediate
- in_target  in  26  J-type target
- in_last  in  1  final bundle of session
- im_we  out  1  IM write request
- im_ready  in  1  IM accepts write this cycle
- im_addr  out  IM_AW  IM word address
- im_wdata  out  32  encoded instruction
- busy  out  1  session active
- done  out  1  one-cycle pulse at session end
- err  out  1  sticky illegal-select flag, cleared on start
- count  out  IM_AW+1  words written this session

Behaviour:
- Reset: state IDLE, FIFO empty. in_ready, im_we, im_addr, im_wdata, busy, done, err and count are all 0.
- in_sel codes:
  - R-type (op 0, funct): 0 add 0x20, 1 sub 0x22, 2 and 0x24, 3 or 0x25, 4 slt 0x2A, 5 sltu 0x2B, 6 addu 0x21, 7 subu 0x23, 8 jr 0x08, 9 jalr 0x09, 10 nor 0x27, 11 sll 0x00, 12 srl 0x02, 13 sra 0x03, 14 sllv 0x04, 15 srlv 0x06.
  - I-type opcodes: 16 addi 0x08, 17 ori 0x0D, 18 lw 0x23, 19 sw 0x2B, 20 beq 0x04, 21 bne 0x05, 22 slti 0x0A.
  - J-type opcodes: 23 j 0x02, 24 jal 0x03.
  - Codes 25-31 are illegal.
- Encoding formats:
  - R-type is {6'b0, rs, rt, rd, shamt, funct}.
  - shamt is forced to 0 except for sll/srl/sra; rs is forced to 0 for sll/srl/sra.
  - jr forces rt, rd and shamt to 0; jalr forces rt and shamt to 0.
  - I-type is {op, rs, rt, imm}. J-type is {op, target}.
- States:
  - IDLE: in_ready=0. On start go to LOAD; addr<=base_addr, count<=0, err<=0.
  - LOAD: in_ready = !fifo_full. A handshake (in_valid & in_ready) encodes the bundle and pushes it at that edge. Handshake with in_last goes to DRAIN.
  - DRAIN: in_ready=0. When FIFO is empty and im_we=0, pulse done for one cycle and go to IDLE.
- Illegal in_sel: bundle is accepted and discarded (no push), err<=1. in_last on an illegal bundle still ends the session.
- Write side (LOAD and DRAIN):
  - If im_we=0, or im_we & im_ready, and the FIFO is non-empty: pop and register im_wdata, im_addr<=addr, im_we<=1.
  - A bundle accepted at edge k appears on im_* after edge k+1 at the earliest.
- IM handshake:
  - im_we/im_addr/im_wdata hold stable while im_ready=0.
  - On im_we & im_ready: addr and count increment. im_we drops unless a new pop occurs the same edge, giving back-to-back throughput of 1 word/cycle.
- Wrap and counting: addr wraps modulo 2^IM_AW. count increments per accepted write, modulo 2^(IM_AW+1).
- Simultaneous push and pop are legal. Push is gated only by full as seen at the start of the cycle.
- busy = (state != IDLE).
- start while busy has no effect.
- rst mid-session: aborts immediately, FIFO flushed, no done pulse, all outputs return to reset values.

Test Plan:
- start base_addr=0x010, single addi rs=0 rt=8 imm=0x0005 in_last, im_ready=1 -> one write addr 0x010 data 0x20080005; done pulses; count=1; busy falls.
- Stream, all written with im_ready=1:
  - add rs=9 rt=10 rd=8 shamt=3 -> 0x012A4020 (shamt zeroed)
  - sw rs=29 rt=31 imm=0xFFFC -> 0xAFBFFFFC
  - j target=0x0100000 -> 0x08100000
  - sll rs=5 rt=0 rd=0 shamt=0 -> 0x00000000
  - Addresses are consecutive.
- Back-pressure: im_ready=0 for 10 cycles while 6 bundles offered -> in_ready drops after FIFO_DEPTH+1 accepts, im_* stable. im_ready=1 -> all 6 written in order, none lost or duplicated.
- Wrap: base_addr=0x3FF, two valid words -> addresses 0x3FF then 0x000; count=2.
- Illegal: sequence ori, in_sel=27, addi(last) -> err=1; two writes at base and base+1; done still pulses; next start clears err.
- rst asserted mid-stream with FIFO non-empty -> next cycle im_we=0, busy=0, count=0, no done. A new start session loads correctly from its base_addr.
